// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: data/address widths, access sizes,
// FSM states and the access-fault check used at request acceptance.
package load_store_unit_pkg;

  localparam int WordWidth = 32;
  localparam int AddrWidth = 32;

  typedef logic [WordWidth-1:0] Word;
  typedef logic [AddrWidth-1:0] RamAddress;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } MemSize;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_WRITE,
    ST_ERROR
  } lsu_state_e;

  // Reserved size or an offset that does not fit the access width.
  function automatic logic is_access_fault(input MemSize size, input logic [1:0] offset);
    logic fault;
    case (size)
      MEM_BYTE: fault = 1'b0;
      MEM_HALF: fault = offset[0];
      MEM_WORD: fault = (offset != 2'b00);
      default:  fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response handshake plus the word-RAM port of the unit.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic      req_valid;
  logic      req_ready;
  logic      req_write;
  MemSize    req_size;
  logic      req_unsigned;
  RamAddress req_address;
  Word       req_data;
  logic      resp_valid;
  Word       resp_data;
  logic      resp_error;
  logic      ram_write_enable;
  RamAddress ram_address;
  Word       ram_in;
  Word       ram_out;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_address, req_data, ram_out,
    output req_ready, resp_valid, resp_data, resp_error, ram_write_enable, ram_address, ram_in
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_data, ram_out,
    input  req_ready, resp_valid, resp_data, resp_error, ram_write_enable, ram_address, ram_in
  );
endinterface

// File: rtl/load_store_unit_lane_merge.sv
// Little-endian lane logic shared by both paths: extract/extend a load lane
// and merge sub-word store data into the surrounding RAM word.
module mem_lane_merge
  import load_store_unit_pkg::*;
(
  input  Word        i_word,
  input  Word        i_store_data,
  input  MemSize     i_size,
  input  logic [1:0] i_offset,
  input  logic       i_unsigned,
  output Word        o_load_data,
  output Word        o_merged
);
  Word        w_shifted;
  Word        w_mask;
  Word        w_lanes;
  logic [4:0] w_shift;

  assign w_shift   = {i_offset, 3'b000};
  assign w_shifted = i_word >> w_shift;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    o_load_data = i_word;
    w_mask      = '1;
    w_lanes     = i_store_data;
    case (i_size)
      MEM_BYTE: begin
        o_load_data = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
        w_mask      = Word'(32'h0000_00FF) << w_shift;
        w_lanes     = {4{i_store_data[7:0]}};
      end
      MEM_HALF: begin
        o_load_data = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
        w_mask      = Word'(32'h0000_FFFF) << w_shift;
        w_lanes     = {2{i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign o_merged = (i_word & ~w_mask) | (w_lanes & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives a word-wide RAM and
// completes loads/word stores in one cycle, sub-word stores via read-merge-write.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  lsu_state_e r_state;
  logic       r_ready;
  logic       r_resp_valid;
  logic       r_resp_error;
  logic       r_ram_we;
  logic       r_write;
  logic       r_unsigned;
  MemSize     r_size;
  RamAddress  r_address;
  Word        r_data;
  Word        r_ram_in;

  Word       w_load_data;
  Word       w_merged;
  RamAddress w_ram_address;
  logic      w_accept;

  assign w_accept = bus.req_valid && r_ready;

  // Both lane paths work on the latched request against the RAM word being read.
  mem_lane_merge u_lane (
    .i_word       (bus.ram_out),
    .i_store_data (r_data),
    .i_size       (r_size),
    .i_offset     (r_address[1:0]),
    .i_unsigned   (r_unsigned),
    .o_load_data  (w_load_data),
    .o_merged     (w_merged)
  );

  assign w_ram_address        = reset ? '0 : (r_state == ST_IDLE) ? bus.req_address : r_address;
  assign bus.ram_address      = {w_ram_address[AddrWidth-1:2], 2'b00};
  assign bus.ram_in           = r_ram_in;
  assign bus.ram_write_enable = r_ram_we;
  assign bus.req_ready        = r_ready;
  assign bus.resp_valid       = r_resp_valid;
  assign bus.resp_error       = r_resp_error;
  assign bus.resp_data        = (r_state == ST_LOAD && !r_write) ? w_load_data : '0;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ready      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_ram_we     <= 1'b0;
      r_write      <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= MEM_BYTE;
      r_address    <= '0;
      r_data       <= '0;
      r_ram_in     <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_ram_we     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_ready    <= 1'b0;
            r_write    <= bus.req_write;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_address  <= bus.req_address;
            r_data     <= bus.req_data;
            if (is_access_fault(bus.req_size, bus.req_address[1:0])) begin
              r_state      <= ST_ERROR;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
            end else if (!bus.req_write) begin
              r_state      <= ST_LOAD;
              r_resp_valid <= 1'b1;
            end else if (bus.req_size == MEM_WORD) begin
              r_state      <= ST_WRITE;
              r_ram_in     <= bus.req_data;
              r_ram_we     <= 1'b1;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          r_ram_in     <= w_merged;
          r_ram_we     <= 1'b1;
          r_resp_valid <= 1'b1;
          r_state      <= ST_WRITE;
        end
        ST_LOAD, ST_WRITE, ST_ERROR: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
